// File: rtl/tcpu_pkg.sv
// Shared types and constants for the TCPU fetch/execute sequencer.
// TCPU_SEQ_STEP_EN adds the PAUSE state used for single-stepping.
package tcpu_pkg;

    localparam int INSN_W = 16;

    localparam logic [2:0] OPC_REG = 3'b000;
    localparam logic [2:0] OPC_IMM = 3'b001;
    localparam logic [2:0] OPC_LI  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
`ifdef TCPU_SEQ_STEP_EN
        ,
        ST_PAUSE = 3'd5
`endif
    } seq_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/tcpu_fetch_timer.sv
// Counts FETCH cycles spent waiting for an instruction-memory ack.
// expire is high on the last cycle a fetch may wait before it faults.
module tcpu_fetch_timer #(
    parameter int FETCH_TMO = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(FETCH_TMO - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'd0;
        end else if (inc) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == LAST);

endmodule

// File: rtl/tcpu_seq.sv
// Multi-cycle fetch/execute sequencer for the TCPU core: PC, IR, run/halt/fault.
// Define TCPU_SEQ_STEP_EN to add the step input and single-step PAUSE state.
module tcpu_seq
    import tcpu_pkg::*;
#(
    parameter int              PC_W      = 8,
    parameter logic [PC_W-1:0] RST_PC    = '0,
    parameter int              FETCH_TMO = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef TCPU_SEQ_STEP_EN
    input  logic              step,
`endif
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INSN_W-1:0] imem_rdata,
    output logic [INSN_W-1:0] ir,
    input  logic              dec_we,
    input  logic              dec_halt,
    output logic              rf_we,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
    output logic              fault,
    output logic [15:0]       retired
);

    seq_state_t        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INSN_W-1:0] ir_q, ir_d;
    logic [15:0]       retired_q, retired_d;
    logic              timer_clr;
    logic              timer_inc;
    logic              timer_expire;

    tcpu_fetch_timer #(
        .FETCH_TMO (FETCH_TMO)
    ) u_fetch_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (timer_clr),
        .inc    (timer_inc),
        .expire (timer_expire)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        timer_clr = 1'b1;
        timer_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // An ack on the expiring cycle still wins over the timeout.
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_EXEC;
                end else begin
                    timer_clr = 1'b0;
                    timer_inc = 1'b1;
                    if (timer_expire) begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_EXEC: begin
                if (dec_halt) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d      = pc_q + PC_W'(1);
                    retired_d = sat_inc16(retired_q);
`ifdef TCPU_SEQ_STEP_EN
                    state_d   = ST_PAUSE;
`else
                    state_d   = ST_FETCH;
`endif
                end
            end
            ST_HALT: begin
                // The halting instruction is retired only when execution resumes.
                if (start) begin
                    pc_d      = pc_q + PC_W'(1);
                    retired_d = sat_inc16(retired_q);
                    state_d   = ST_FETCH;
                end
            end
`ifdef TCPU_SEQ_STEP_EN
            ST_PAUSE: begin
                if (step) begin
                    state_d = ST_FETCH;
                end
            end
`endif
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RST_PC;
            ir_q      <= '0;
            retired_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // Status outputs decode the state register directly, so reset drops them at once.
    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign halted    = (state_q == ST_HALT);
    assign fault     = (state_q == ST_FAULT);
    assign rf_we     = (state_q == ST_EXEC) && dec_we;
    assign ir        = ir_q;
    assign pc        = pc_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_tcpu_seq.sv
// Self-checking bench for tcpu_seq: vector table, hand-written corner sequences
// and a randomized program checked against a transaction-level model.
module tb_tcpu_seq;
    import tcpu_pkg::*;

    localparam logic [15:0] HALT_WORD = 16'h0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        dec_we;
    logic        dec_halt;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] ir;
    logic        rf_we;
    logic [7:0]  pc;
    logic        halted;
    logic        fault;
    logic [15:0] retired;

    logic        w_start;
    logic        w_req;
    logic [1:0]  w_addr;
    logic [15:0] w_ir;
    logic        w_rf_we;
    logic [1:0]  w_pc;
    logic        w_halted;
    logic        w_fault;
    logic [15:0] w_retired;
`ifdef TCPU_SEQ_STEP_EN
    logic        step;
    logic        w_step;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- decoder model ----------------
    function automatic logic dec_we_of(input logic [15:0] w);
        return (w != HALT_WORD) && (w[15:13] inside {OPC_REG, OPC_IMM, OPC_LI});
    endfunction

    assign dec_halt = (ir == HALT_WORD);
    assign dec_we   = dec_we_of(ir);

    // ---------------- DUTs ----------------
    tcpu_seq #(.PC_W(8), .RST_PC(8'd0), .FETCH_TMO(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
`ifdef TCPU_SEQ_STEP_EN
        .step       (step),
`endif
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .dec_we     (dec_we),
        .dec_halt   (dec_halt),
        .rf_we      (rf_we),
        .pc         (pc),
        .halted     (halted),
        .fault      (fault),
        .retired    (retired)
    );

    tcpu_seq #(.PC_W(2), .RST_PC(2'd3), .FETCH_TMO(15)) u_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (w_start),
`ifdef TCPU_SEQ_STEP_EN
        .step       (w_step),
`endif
        .imem_req   (w_req),
        .imem_addr  (w_addr),
        .imem_ack   (1'b1),
        .imem_rdata (16'h0C15),
        .ir         (w_ir),
        .dec_we     (1'b1),
        .dec_halt   (1'b0),
        .rf_we      (w_rf_we),
        .pc         (w_pc),
        .halted     (w_halted),
        .fault      (w_fault),
        .retired    (w_retired)
    );

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        w_start    = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0;
`ifdef TCPU_SEQ_STEP_EN
        step       = 1'b0;
        w_step     = 1'b1;
`endif
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called at a negedge while FETCH is expected; returns at the negedge after EXEC.
    task automatic do_insn(input logic [15:0] word, input int delay,
                           input logic [7:0] exp_addr, input logic [15:0] prev_ir);
        for (int i = 0; i < delay; i++) begin
            chk("req_wait", 32'(imem_req), 32'd1);
            chk("addr_wait", 32'(imem_addr), 32'(exp_addr));
            chk("ir_hold", 32'(ir), 32'(prev_ir));
            chk("rf_we_fetch", 32'(rf_we), 32'd0);
            imem_ack   = 1'b0;
            imem_rdata = 16'($urandom);
            tick();
        end
        chk("req", 32'(imem_req), 32'd1);
        chk("addr", 32'(imem_addr), 32'(exp_addr));
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        chk("ir_load", 32'(ir), 32'(word));
        chk("exec_req", 32'(imem_req), 32'd0);
        chk("rf_we_exec", 32'(rf_we), 32'(dec_we_of(word)));
        // A stray ack outside FETCH must not touch the IR.
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = 16'($urandom);
        tick();
        imem_ack = 1'b0;
        chk("ir_after_exec", 32'(ir), 32'(word));
`ifdef TCPU_SEQ_STEP_EN
        if (word != HALT_WORD) begin
            chk("pause_req", 32'(imem_req), 32'd0);
            tick();
            chk("pause_hold", 32'(imem_req), 32'd0);
            step = 1'b1;
            tick();
            step = 1'b0;
        end
`endif
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] word;
        int          delay;
        logic [7:0]  addr;
        logic [7:0]  pc_after;
        logic [15:0] ret_after;
        logic        halt_after;
    } vec_t;

    vec_t tbl[7];

    logic [15:0] mem[256];
    logic [7:0]  exp_q[$];

    initial begin
        logic [15:0] prev;
        logic [7:0]  m_pc;
        logic [15:0] m_ret;
        logic [7:0]  a;

        tbl[0] = '{16'h0C15, 0, 8'd0, 8'd1, 16'd1, 1'b0};
        tbl[1] = '{16'h0C15, 0, 8'd1, 8'd2, 16'd2, 1'b0};
        tbl[2] = '{16'h0C15, 0, 8'd2, 8'd3, 16'd3, 1'b0};
        tbl[3] = '{16'h0C15, 0, 8'd3, 8'd4, 16'd4, 1'b0};
        tbl[4] = '{16'h4C15, 3, 8'd4, 8'd5, 16'd5, 1'b0};
        tbl[5] = '{16'hE123, 1, 8'd5, 8'd6, 16'd6, 1'b0};
        tbl[6] = '{HALT_WORD, 2, 8'd6, 8'd6, 16'd6, 1'b1};

        // ---- reset values ----
        rst_n      = 1'b0;
        start      = 1'b0;
        w_start    = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0;
`ifdef TCPU_SEQ_STEP_EN
        step       = 1'b0;
        w_step     = 1'b1;
`endif
        repeat (2) tick();
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_ir", 32'(ir), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_w_pc", 32'(w_pc), 32'd3);
        chk("rst_w_ir", 32'(w_ir), 32'd0);
        chk("rst_w_flags", {29'd0, w_halted, w_fault, w_rf_we}, 32'd0);
        chk("rst_w_retired", 32'(w_retired), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_req", 32'(imem_req), 32'd0);

        // ---- PC wrap on a 2-bit PC starting at 3 ----
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        chk("wrap_req", 32'(w_req), 32'd1);
        chk("wrap_addr", 32'(w_addr), 32'd3);
        tick();
        chk("wrap_rf_we", 32'(w_rf_we), 32'd1);
        tick();
        chk("wrap_pc", 32'(w_pc), 32'd0);

        // ---- table-driven program ----
        pulse_start();
        prev = 16'h0;
        for (int i = 0; i < 7; i++) begin
            do_insn(tbl[i].word, tbl[i].delay, tbl[i].addr, prev);
            prev = tbl[i].word;
            chk("tbl_pc", 32'(pc), 32'(tbl[i].pc_after));
            chk("tbl_retired", 32'(retired), 32'(tbl[i].ret_after));
            chk("tbl_halted", 32'(halted), 32'(tbl[i].halt_after));
`ifndef TCPU_SEQ_STEP_EN
            chk("tbl_req", 32'(imem_req), 32'(!tbl[i].halt_after));
`endif
        end

        // ---- halt hold and resume ----
        tick();
        chk("halt_hold", 32'(halted), 32'd1);
        chk("halt_req", 32'(imem_req), 32'd0);
        pulse_start();
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", 32'(imem_addr), 32'd7);
        chk("resume_retired", 32'(retired), 32'd7);

        // ---- ack exactly on the 15th fetch cycle ----
        do_insn(16'h0C15, 14, 8'd7, HALT_WORD);
        chk("late_ack_fault", 32'(fault), 32'd0);
        chk("late_ack_pc", 32'(pc), 32'd8);

        // ---- fetch timeout ----
        imem_ack = 1'b0;
        repeat (14) tick();
        chk("tmo_pre_fault", 32'(fault), 32'd0);
        chk("tmo_pre_req", 32'(imem_req), 32'd1);
        tick();
        chk("tmo_fault", 32'(fault), 32'd1);
        chk("tmo_req", 32'(imem_req), 32'd0);
        pulse_start();
        tick();
        chk("fault_sticky", 32'(fault), 32'd1);
        chk("fault_no_req", 32'(imem_req), 32'd0);
        chk("fault_pc", 32'(pc), 32'd8);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_clears_fault", 32'(fault), 32'd0);
        chk("rst_clears_pc", 32'(pc), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // ---- reset mid-fetch, late ack ignored ----
        pulse_start();
        chk("midf_req", 32'(imem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midf_req_drop", 32'(imem_req), 32'd0);
        tick();
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        tick();
        imem_ack = 1'b0;
        chk("late_ack_ir", 32'(ir), 32'd0);
        chk("late_ack_req", 32'(imem_req), 32'd0);

        // ---- randomized program vs. transaction model ----
        do_reset();
        for (int i = 0; i < 256; i++) begin
            mem[i] = ($urandom_range(0, 7) == 0) ? HALT_WORD : 16'($urandom);
        end
        // Every instruction, halting or not, eventually advances the PC by one.
        for (int k = 0; k < 40; k++) exp_q.push_back(8'(k));
        m_pc  = 8'd0;
        m_ret = 16'd0;
        prev  = 16'h0;
        pulse_start();
        while (exp_q.size() > 0) begin
            a = exp_q.pop_front();
            chk("rnd_model_pc", 32'(a), 32'(m_pc));
            do_insn(mem[a], $urandom_range(0, 5), a, prev);
            prev = mem[a];
            if (mem[a] == HALT_WORD) begin
                chk("rnd_halted", 32'(halted), 32'd1);
                chk("rnd_halt_pc", 32'(pc), 32'(m_pc));
                chk("rnd_halt_ret", 32'(retired), 32'(m_ret));
                repeat ($urandom_range(0, 3)) tick();
                pulse_start();
            end
            m_pc  = m_pc + 8'd1;
            m_ret = (m_ret == 16'hFFFF) ? m_ret : m_ret + 16'd1;
            chk("rnd_pc", 32'(pc), 32'(m_pc));
            chk("rnd_retired", 32'(retired), 32'(m_ret));
            chk("rnd_fault", 32'(fault), 32'd0);
        end

        // ---- final report ----
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tcpu_seq.md
Name: tcpu_seq

Overview:
- Multi-cycle fetch/execute sequencer for the TCPU core.
- Fetches 16-bit instructions from instruction memory over a req/ack handshake and holds each one in an instruction register (IR).
- The IR drives the instruction decoder combinationally. The decoder's register-file write-enable and halt outputs come back into this block.
- Owns the PC, run/halt/fault control, and gates register-file writes to exactly one cycle per instruction.

Parameters:
- PC_W, 8, width of PC and instruction-memory address.
- RST_PC, 0, PC value after reset.
- FETCH_TMO, 15, maximum FETCH cycles without ack before entering FAULT (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse. IDLE->FETCH; HALT->resume.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  16  instruction word.
- ir  out  16  instruction register, to decoder input.
- dec_we  in  1  decoder register-write request.
- dec_halt  in  1  decoder halt indication.
- rf_we  out  1  gated register-file write enable.
- pc  out  PC_W  current PC.
- halted  out  1  high in HALT.
- fault  out  1  sticky fetch-timeout flag.
- retired  out  16  retired-instruction count, saturating.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, pc=RST_PC, ir=0.
  - imem_req=0, rf_we=0, halted=0, fault=0, retired=0, timer=0.
- States: IDLE, FETCH, EXEC, HALT, FAULT. All outputs are registered or a direct decode of state; the only exception is rf_we.
- IDLE:
  - imem_req=0.
  - start=1 -> FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until ack.
  - imem_ack=1 -> ir<=imem_rdata, timer<=0, go EXEC.
  - No ack -> timer++.
  - timer reaching FETCH_TMO-1 with no ack -> FAULT, with imem_req=0 the next cycle.
  - Ack in the same cycle as the timeout wins: go EXEC, no fault.
- EXEC (exactly 1 cycle):
  - rf_we = dec_we (combinational; 0 in every other state).
  - dec_halt=1 -> HALT; pc is unchanged and retired is not incremented.
  - Otherwise pc<=pc+1 (wraps modulo 2^PC_W), retired<=retired+1 (saturates at 16'hFFFF), go FETCH.
- HALT:
  - halted=1, imem_req=0.
  - start=1 -> pc<=pc+1, retired+1, go FETCH, halted clears the next cycle.
- FAULT:
  - fault=1, imem_req=0.
  - Terminal until rst_n.
- Ignored inputs:
  - start outside IDLE/HALT.
  - imem_ack outside FETCH.
  - dec_we/dec_halt outside EXEC.
- Throughput: minimum 2 cycles per instruction (FETCH with ack in the same cycle, then EXEC).
- Reset mid-fetch drops imem_req asynchronously. A late ack after reset is ignored because the state is IDLE.

Optional Feature:
- Macro: TCPU_SEQ_STEP_EN.
- Defined:
  - Adds input port step (1 bit) and state PAUSE.
  - A non-halting EXEC goes to PAUSE instead of FETCH, after the pc/retired update.
  - PAUSE: imem_req=0, halted=0. step=1 -> FETCH.
  - start has no effect in PAUSE.
- Undefined:
  - No step port and no PAUSE state.
  - EXEC goes directly to FETCH.

Decomposition:
- tcpu_pkg:
  - state enum seq_state_t.
  - INSN_W=16.
  - opcode-class constants OPC_REG=3'b000, OPC_IMM=3'b001, OPC_LI=3'b010.
- Sub-module tcpu_fetch_timer:
  - 8-bit counter with clr, inc and expire output against FETCH_TMO.
  - Instantiated once.

Test Plan:
- Reset then start; memory acks the same cycle with 16'h0C15 at addresses 0..3 -> each instruction takes 2 cycles; rf_we=dec_we only in EXEC; pc=4 and retired=4 after 8 cycles.
- Ack delayed 3 cycles -> imem_req/imem_addr stable for 4 cycles; ir is loaded only on the ack cycle.
- Instruction 16'h0001 (halt) at pc=2 -> HALT with pc=2, halted=1, retired=2; start -> fetch from pc=3.
- No ack for 15 cycles -> fault=1, imem_req=0; start ignored; rst_n low clears the fault.
- Ack arrives on cycle 15 exactly -> EXEC entered, fault stays 0.
- PC_W=2 running from pc=3 -> wraps to 0. With TCPU_SEQ_STEP_EN: one instruction per step pulse; no fetch while paused.
